booth_seq_mult: RTL

- Iterative signed radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH.
- Recodes the multiplier into 3-bit Booth codes, one per cycle, and decodes each into zero/one/two/neg.
- Each partial product is conditioned and accumulated, so one product takes WIDTH/2 iterations.
- Serves as the sequential counterpart in the multiplier datapath: it generates the codes and consumes the partial product plus the neg carry-in.

---
 rtl/booth_seq_mult.sv | 139 +++++++++++++
 1 files changed

// File: rtl/booth_seq_mult.sv
// rtl/booth_seq_mult.sv - iterative signed radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH
// Optional BOOTH_EARLY_TERM_EN: finish as soon as all remaining Booth codes are zero.
module booth_seq_mult #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH/2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   prod,
  output logic                 busy
);

  localparam int PW = 2*WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   count_q;
  logic [PW-1:0]      acc_q;
  logic [PW-1:0]      prod_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH:0]     b_ext_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [CNT_W:0]     shamt;
  logic [WIDTH:0]     b_sh;
  logic [2:0]         code;
  logic               pp_one;
  logic               pp_two;
  logic               pp_neg;
  logic [PW-1:0]      a_sx;
  logic [PW-1:0]      pp;
  logic [PW-1:0]      pp_cond;
  logic [PW-1:0]      acc_d;
  logic               last_iter;
  logic               stop_d;
`ifdef BOOTH_EARLY_TERM_EN
  logic [WIDTH:0]     rem_mask;
  logic [WIDTH:0]     rem_bits;
`endif

  always_comb begin
    shamt  = {count_q, 1'b0};
    b_sh   = b_ext_q >> shamt;
    code   = b_sh[2:0];
    pp_one = 1'b0;
    pp_two = 1'b0;
    pp_neg = 1'b0;
    case (code)
      3'b001, 3'b010: pp_one = 1'b1;
      3'b011:         pp_two = 1'b1;
      3'b100:         begin pp_two = 1'b1; pp_neg = 1'b1; end
      3'b101, 3'b110: begin pp_one = 1'b1; pp_neg = 1'b1; end
      default:        ;
    endcase

    a_sx = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    pp   = '0;
    if (pp_one) pp = a_sx;
    if (pp_two) pp = a_sx << 1;
    // Negation is ~pp here plus a carry injected at the same bit weight in one adder.
    pp_cond = pp_neg ? ~pp : pp;
    acc_d   = acc_q + (pp_cond << shamt) + (PW'(pp_neg) << shamt);

    last_iter = (count_q == CNT_W'(WIDTH/2 - 1));
`ifdef BOOTH_EARLY_TERM_EN
    rem_mask = {(WIDTH+1){1'b1}} << (int'(shamt) + 2);
    rem_bits = b_ext_q & rem_mask;
    stop_d   = last_iter || (rem_bits == '0) || (rem_bits == rem_mask);
`else
    stop_d   = last_iter;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      a_q         <= '0;
      b_ext_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_ext_q    <= {b, 1'b0};
            acc_q      <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          count_q <= count_q + CNT_W'(1);
          if (stop_d) begin
            prod_q      <= acc_d;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign prod      = prod_q;

endmodule
